// File: rtl/bar_pkg.sv
// bar_pkg: shared FSM encoding, Q4.12 unity gain and default widths for the bar level path
package bar_pkg;
  typedef enum logic [1:0] {ACCUM, SCALE, APPLY} bar_state_t;
  localparam logic [15:0] GAIN_ONE = 16'h1000;
  localparam int SAMPLE_BITS_DEF = 12;
  localparam int X_BITS_DEF = 13;
endpackage

// File: rtl/vsync_edge_sync.sv
// vsync_edge_sync: brings an asynchronous vsync into clk and emits a one-cycle pulse on its rising edge
//  clk      in  clock of the receiving domain
//  rst_n    in  synchronous active-low reset, clears all flops
//  vsync    in  asynchronous frame strobe
//  vs_rise  out registered one-cycle pulse per synchronised rising edge
module vsync_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync,
  output logic vs_rise
);
  logic meta, sync, sync_d;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta    <= 1'b0;
      sync    <= 1'b0;
      sync_d  <= 1'b0;
      vs_rise <= 1'b0;
    end else begin
      meta    <= vsync;
      sync    <= meta;
      sync_d  <= sync;
      vs_rise <= sync & ~sync_d;
    end
  end
endmodule

// File: rtl/bar_level_tracker.sv
// bar_level_tracker: per-frame peak magnitude of a sample stream scaled to a bar length with attack/decay
//  clk              in  single clock domain
//  rst_n            in  synchronous active-low reset
//  sample_in        in  signed sample
//  sample_valid     in  sample_in valid
//  sample_ready     out sample accepted when valid & ready; low only while a frame is being closed
//  vsync            in  asynchronous frame strobe, rising edge closes a frame
//  gain             in  unsigned Q4.FRACTIONAL_BITS scale
//  total_active_pix in  bar length saturation limit
//  value            out bar length in pixels, held between updates
//  value_valid      out one-cycle pulse when value updates
module bar_level_tracker import bar_pkg::*; #(
  parameter int SAMPLE_BITS     = SAMPLE_BITS_DEF,
  parameter int X_BITS          = X_BITS_DEF,
  parameter int FRACTIONAL_BITS = 12,
  parameter int DECAY_STEP      = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic signed [SAMPLE_BITS-1:0] sample_in,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  input  logic                          vsync,
  input  logic [4+FRACTIONAL_BITS-1:0]  gain,
  input  logic [X_BITS-1:0]             total_active_pix,
  output logic [X_BITS-1:0]             value,
  output logic                          value_valid
);
  localparam int MAG_W  = SAMPLE_BITS - 1;
  localparam int GAIN_W = 4 + FRACTIONAL_BITS;
  localparam int PROD_W = MAG_W + GAIN_W;
  localparam int SH_W   = PROD_W - FRACTIONAL_BITS;
  bar_state_t state, state_nxt;
  logic vs_rise;
  logic [MAG_W-1:0] mag, peak;
  logic [SH_W-1:0] prod_sh;
  logic [X_BITS-1:0] tgt, decayed, held, value_nxt;
  vsync_edge_sync u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .vsync   (vsync),
    .vs_rise (vs_rise)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ACCUM;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = ACCUM;
    if (state == ACCUM && vs_rise) state_nxt = SCALE;
    else if (state == SCALE) state_nxt = APPLY;
  end
  // The most negative sample has no positive twin, so it saturates to the largest magnitude.
  always_comb begin
    mag = !sample_in[SAMPLE_BITS-1] ? sample_in[MAG_W-1:0] :
          (~|sample_in[MAG_W-1:0]) ? '1 : MAG_W'(-sample_in);
    tgt = (prod_sh > SH_W'(total_active_pix)) ? total_active_pix : X_BITS'(prod_sh);
    decayed = (value > X_BITS'(DECAY_STEP)) ? value - X_BITS'(DECAY_STEP) : '0;
    held = (tgt >= value) ? tgt : ((tgt > decayed) ? tgt : decayed);
    // A decaying value can still sit above a freshly lowered limit; clamp it here.
    value_nxt = (held > total_active_pix) ? total_active_pix : held;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      peak         <= '0;
      prod_sh      <= '0;
      value        <= '0;
      value_valid  <= 1'b0;
      sample_ready <= 1'b0;
    end else begin
      value_valid  <= 1'b0;
      sample_ready <= (state_nxt == ACCUM);
      if (state == ACCUM && sample_valid && sample_ready && mag > peak) peak <= mag;
      if (state == SCALE) begin
        prod_sh <= SH_W'((PROD_W'(peak) * PROD_W'(gain)) >> FRACTIONAL_BITS);
        peak    <= '0;
      end
      if (state == APPLY) begin
        value       <= value_nxt;
        value_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bar_level_tracker.sv
// tb_bar_level_tracker: directed and randomized frames checked against a per-frame peak/attack/decay model
module tb_bar_level_tracker;
  import bar_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic signed [11:0] sample_in = '0;
  logic sample_valid = 1'b0;
  logic sample_ready;
  logic vsync = 1'b0;
  logic [15:0] gain = GAIN_ONE;
  logic [12:0] total_active_pix = 13'd1280;
  logic [12:0] value;
  logic value_valid;
  int total = 0, bad = 0;
  int m_peak = 0, m_value = 0, lo_run = -1;
  bit prev_vv = 1'b0;
  int e_tgt, e_dec, e_res;
  longint e_prod;
  always #5 clk = ~clk;
  bar_level_tracker dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .sample_in        (sample_in),
    .sample_valid     (sample_valid),
    .sample_ready     (sample_ready),
    .vsync            (vsync),
    .gain             (gain),
    .total_active_pix (total_active_pix),
    .value            (value),
    .value_valid      (value_valid)
  );
  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask
  function automatic int mag_of(input logic signed [11:0] s);
    int a = int'(s);
    if (a < 0) a = -a;
    return (a > 2047) ? 2047 : a;
  endfunction
  always @(negedge clk) begin
    if (!rst_n) begin
      m_peak = 0;
      m_value = 0;
      lo_run = -1;
      prev_vv = 1'b0;
    end else begin
      if (value_valid) begin
        e_prod = longint'(m_peak) * longint'(gain);
        e_tgt = int'(e_prod >> 12);
        if (e_tgt > int'(total_active_pix)) e_tgt = int'(total_active_pix);
        e_dec = (m_value > 4) ? m_value - 4 : 0;
        e_res = (e_tgt >= m_value) ? e_tgt : ((e_tgt > e_dec) ? e_tgt : e_dec);
        if (e_res > int'(total_active_pix)) e_res = int'(total_active_pix);
        m_value = e_res;
        m_peak = 0;
        check("value", int'(value), m_value);
        check("vv_single", int'(prev_vv), 0);
      end else check("hold", int'(value), m_value);
      if (!sample_ready) lo_run++;
      else begin
        if (lo_run > 0) begin
          check("ready_low_len", lo_run, 2);
          check("vv_on_resume", int'(value_valid), 1);
        end
        lo_run = 0;
      end
      if (sample_valid && sample_ready && mag_of(sample_in) > m_peak) m_peak = mag_of(sample_in);
      prev_vv = value_valid;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input int s);
    sample_in = 12'(s);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask
  task automatic close_frame(input bit hold, input bit glitch);
    int n = 0, extra = 0;
    sample_valid = hold;
    sample_in = 12'(int'($urandom_range(0, 400)) - 200);
    vsync = 1'b1;
    if (glitch) begin
      tick();
      vsync = 1'b0;
      tick();
      vsync = 1'b1;
    end
    while (!value_valid && n < 40) begin
      sample_in = sample_ready ? 12'(int'($urandom_range(0, 400)) - 200) : 12'sd2000;
      tick();
      n++;
    end
    check("update_seen", int'(value_valid), 1);
    sample_in = 12'(int'($urandom_range(0, 400)) - 200);
    for (int i = 0; i < 8; i++) begin
      tick();
      vsync = 1'b0;
      if (value_valid) extra++;
    end
    check("no_extra_update", extra, 0);
    sample_valid = 1'b0;
  endtask
  initial begin
    int n, n_vv;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check("reset_value", int'(value), 0);
    send(100); send(-300); send(200);
    close_frame(0, 0);
    check("t2_value", int'(value), 300);
    send(500);
    sample_valid = 1'b1;
    rst_n = 1'b0;
    repeat (5) tick();
    check("t1_value", int'(value), 0);
    check("t1_vv", int'(value_valid), 0);
    check("t1_ready", int'(sample_ready), 0);
    rst_n = 1'b1;
    sample_valid = 1'b0;
    check("t1_ready_pre", int'(sample_ready), 0);
    tick();
    check("t1_ready_post", int'(sample_ready), 1);
    send(100); send(-300); send(200);
    close_frame(0, 0);
    check("t2b_value", int'(value), 300);
    close_frame(0, 0);
    check("t4_decay1", int'(value), 296);
    close_frame(0, 0);
    check("t4_decay2", int'(value), 292);
    close_frame(0, 0);
    check("t4_decay3", int'(value), 288);
    send(290);
    close_frame(0, 0);
    check("t4_attack", int'(value), 290);
    gain = 16'h4000;
    send(-2048);
    close_frame(0, 0);
    check("t3_saturate", int'(value), 1280);
    gain = GAIN_ONE;
    total_active_pix = 13'd500;
    close_frame(0, 0);
    check("clamp_limit", int'(value), 500);
    total_active_pix = 13'd1280;
    send(30);
    close_frame(1, 1);
    send(700);
    vsync = 1'b1;
    n = 0;
    while (sample_ready && n < 20) begin
      tick();
      n++;
    end
    check("t6_in_scale", int'(sample_ready), 0);
    rst_n = 1'b0;
    vsync = 1'b0;
    n_vv = 0;
    repeat (2) begin
      tick();
      if (value_valid) n_vv++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      tick();
      if (value_valid) n_vv++;
    end
    check("t6_no_pulse", n_vv, 0);
    check("t6_value", int'(value), 0);
    send(50);
    close_frame(0, 0);
    check("t6_fresh", int'(value), 50);
    for (int f = 0; f < 40; f++) begin
      gain = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 65535)) : GAIN_ONE;
      total_active_pix = 13'($urandom_range(16, 8191));
      for (int c = 0; c < int'($urandom_range(0, 20)); c++) begin
        sample_valid = 1'($urandom_range(0, 1));
        sample_in = 12'($urandom);
        tick();
      end
      close_frame(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
